// File: rtl/fifo_parity_deframer_pkg.sv
// Shared types, defaults and parity helper for the fifo parity deframer.
package fifo_parity_deframer_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } deframer_state_t;

    localparam int unsigned DEFRAMER_WORDS_DEFAULT = 4;

    // Widest word the parity helper accepts; narrower words are zero-extended,
    // which leaves their parity unchanged.
    localparam int unsigned PARITY_MAX_WIDTH = 64;

    // True when the XOR of all bits (payload plus parity bit) is zero.
    function automatic logic even_parity_ok(input logic [PARITY_MAX_WIDTH-1:0] word);
        return ~(^word);
    endfunction

endpackage

// File: rtl/fifo_parity_deframer_parity_check.sv
// Combinational even-parity check of one popped word (payload plus parity bit).
module fifo_parity_deframer_parity_check
    import fifo_parity_deframer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH:0] data_i,
    output logic                word_ok_o
);

    // Good word: XOR over all DATA_WIDTH+1 bits is zero.
    assign word_ok_o = even_parity_ok(PARITY_MAX_WIDTH'(data_i));

endmodule

// File: rtl/fifo_parity_deframer.sv
// Pops parity-protected words from a fifo, packs WORDS of them into a frame and
// presents clean frames on a valid/grant handshake; frames with bad parity are
// dropped, flagged with a one-cycle pulse and counted.
module fifo_parity_deframer
    import fifo_parity_deframer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned WORDS         = DEFRAMER_WORDS_DEFAULT,
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pop_valid_i,
    input  logic [DATA_WIDTH:0]         pop_data_i,
    output logic                        pop_grant_o,
    output logic                        frame_valid_o,
    output logic [WORDS*DATA_WIDTH-1:0] frame_data_o,
    input  logic                        frame_grant_i,
    output logic                        frame_error_o,
    output logic [ERR_CNT_WIDTH-1:0]    err_count_o
);

    localparam int unsigned IDX_W = $clog2(WORDS);

    deframer_state_t             state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic                        err_flag_q, err_flag_d;
    logic [WORDS*DATA_WIDTH-1:0] data_q, data_d;
    logic                        frame_err_q, frame_err_d;
    logic [ERR_CNT_WIDTH-1:0]    err_cnt_q, err_cnt_d;
    logic                        word_ok;

    fifo_parity_deframer_parity_check #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_check (
        .data_i    (pop_data_i),
        .word_ok_o (word_ok)
    );

    // Grant is a pure function of state, forced low while reset is asserted.
    assign pop_grant_o   = (state_q == COLLECT) && !reset;
    assign frame_valid_o = (state_q == PRESENT);
    assign frame_data_o  = data_q;
    assign frame_error_o = frame_err_q;
    assign err_count_o   = err_cnt_q;

    // Next-state: word collection, frame verdict, handshake and error counting.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        err_flag_d  = err_flag_q;
        data_d      = data_q;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        unique case (state_q)
            COLLECT: begin
                if (pop_valid_i) begin
                    for (int i = 0; i < int'(WORDS); i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            data_d[i*DATA_WIDTH +: DATA_WIDTH] = pop_data_i[DATA_WIDTH-1:0];
                        end
                    end
                    if (idx_q == IDX_W'(WORDS - 1)) begin
                        idx_d      = '0;
                        err_flag_d = 1'b0;
                        if (err_flag_q || !word_ok) begin
                            frame_err_d = 1'b1;
                            if (err_cnt_q != '1) begin
                                err_cnt_d = err_cnt_q + 1'b1;
                            end
                        end else begin
                            state_d = PRESENT;
                        end
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        err_flag_d = err_flag_q || !word_ok;
                    end
                end
            end
            PRESENT: begin
                if (frame_grant_i) begin
                    state_d = COLLECT;
                    idx_d   = '0;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // State registers with synchronous reset; reset also clears the error count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= COLLECT;
            idx_q       <= '0;
            err_flag_q  <= 1'b0;
            data_q      <= '0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            err_flag_q  <= err_flag_d;
            data_q      <= data_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_parity_deframer.sv
// Directed and randomized checks of fifo_parity_deframer against a frame-level model.
module tb_fifo_parity_deframer;

    localparam int DW = 8;
    localparam int NW = 4;
    localparam int CW = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             pop_valid_i;
    logic [DW:0]      pop_data_i;
    logic             pop_grant_o;
    logic             frame_valid_o;
    logic [NW*DW-1:0] frame_data_o;
    logic             frame_grant_i;
    logic             frame_error_o;
    logic [CW-1:0]    err_count_o;

    int checks = 0;
    int errors = 0;
    int pops = 0;
    int err_pulses = 0;
    logic [NW*DW-1:0] got_frames[$];
    bit rand_grant = 1'b0;

    fifo_parity_deframer #(
        .DATA_WIDTH    (DW),
        .WORDS         (NW),
        .ERR_CNT_WIDTH (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pop_valid_i   (pop_valid_i),
        .pop_data_i    (pop_data_i),
        .pop_grant_o   (pop_grant_o),
        .frame_valid_o (frame_valid_o),
        .frame_data_o  (frame_data_o),
        .frame_grant_i (frame_grant_i),
        .frame_error_o (frame_error_o),
        .err_count_o   (err_count_o)
    );

    always #5 clk = ~clk;

    // Records word transfers, frame transfers and drop pulses as they happen.
    always @(posedge clk) begin
        if (!reset) begin
            if (pop_valid_i && pop_grant_o) pops <= pops + 1;
            if (frame_valid_o && frame_grant_i) got_frames.push_back(frame_data_o);
            if (frame_error_o) err_pulses <= err_pulses + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW:0] mkw(input logic [DW-1:0] p, input bit bad);
        return {(^p) ^ bad, p};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        if (rand_grant) frame_grant_i = 1'($urandom_range(0, 1));
        @(negedge clk);
    endtask

    // Offers one word after a gap and returns at the negedge following its transfer.
    task automatic send_word(input logic [DW:0] w, input int gap);
        int n;
        pop_valid_i = 1'b0;
        repeat (gap) step();
        pop_valid_i = 1'b1;
        pop_data_i  = w;
        n = 0;
        while (pop_grant_o !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("send_timeout", 64'(n < 100), 64'd1);
        @(negedge clk);
        pop_valid_i = 1'b0;
    endtask

    logic [DW-1:0]    pl;
    logic [NW*DW-1:0] ef;
    logic [NW*DW-1:0] exp_frames[$];
    bit               rb, fbad;
    int               base_f, base_e, base_p, exp_bad;

    initial begin
        reset = 1'b1;
        pop_valid_i = 1'b0;
        pop_data_i = '0;
        frame_grant_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // Reset state
        check("rst_pop_grant", 64'(pop_grant_o), 64'd0);
        check("rst_frame_valid", 64'(frame_valid_o), 64'd0);
        check("rst_frame_data", 64'(frame_data_o), 64'd0);
        check("rst_frame_error", 64'(frame_error_o), 64'd0);
        check("rst_err_count", 64'(err_count_o), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_pop_grant", 64'(pop_grant_o), 64'd1);

        // Clean frame, continuous input
        frame_grant_i = 1'b1;
        base_e = err_pulses;
        send_word(mkw(8'h03, 0), 0);
        send_word(mkw(8'h05, 0), 0);
        send_word(mkw(8'h06, 0), 0);
        send_word(mkw(8'h0F, 0), 0);
        check("clean_valid", 64'(frame_valid_o), 64'd1);
        check("clean_data", 64'(frame_data_o), 64'h0F060503);
        check("clean_pop_grant", 64'(pop_grant_o), 64'd0);
        @(negedge clk);
        check("clean_valid_drop", 64'(frame_valid_o), 64'd0);
        check("clean_regrant", 64'(pop_grant_o), 64'd1);
        check("clean_no_err", 64'(err_pulses - base_e), 64'd0);

        // Parity error drops frame, then a clean frame follows
        send_word(mkw(8'h03, 0), 0);
        send_word({1'b0, 8'h01}, 0);
        send_word(mkw(8'h05, 0), 0);
        send_word(mkw(8'h06, 0), 0);
        check("perr_pulse", 64'(frame_error_o), 64'd1);
        check("perr_no_valid", 64'(frame_valid_o), 64'd0);
        check("perr_count", 64'(err_count_o), 64'd1);
        @(negedge clk);
        check("perr_pulse_end", 64'(frame_error_o), 64'd0);
        send_word(mkw(8'h11, 0), 0);
        send_word(mkw(8'h12, 0), 0);
        send_word(mkw(8'h14, 0), 0);
        send_word(mkw(8'h18, 0), 0);
        check("perr_next_valid", 64'(frame_valid_o), 64'd1);
        check("perr_next_data", 64'(frame_data_o), 64'h18141211);
        @(negedge clk);

        // Backpressure: frame held, no words consumed
        frame_grant_i = 1'b0;
        ef = '0;
        for (int k = 0; k < NW; k++) begin
            pl = 8'($urandom);
            ef |= (NW*DW)'(pl) << (DW * k);
            send_word(mkw(pl, 0), 0);
        end
        base_p = pops;
        pop_valid_i = 1'b1;
        pop_data_i = mkw(8'h77, 0);
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", 64'(frame_valid_o), 64'd1);
            check("bp_data", 64'(frame_data_o), 64'(ef));
            check("bp_pop_grant", 64'(pop_grant_o), 64'd0);
            @(negedge clk);
        end
        check("bp_no_pops", 64'(pops - base_p), 64'd0);
        frame_grant_i = 1'b1;
        @(negedge clk);
        check("bp_regrant", 64'(pop_grant_o), 64'd1);
        check("bp_valid_drop", 64'(frame_valid_o), 64'd0);
        pop_valid_i = 1'b0;

        // Gapped input
        base_f = got_frames.size();
        base_p = pops;
        ef = '0;
        for (int k = 0; k < NW; k++) begin
            pl = 8'($urandom);
            ef |= (NW*DW)'(pl) << (DW * k);
            send_word(mkw(pl, 0), 3);
        end
        repeat (4) @(negedge clk);
        check("gap_pops", 64'(pops - base_p), 64'd4);
        check("gap_nframes", 64'(got_frames.size() - base_f), 64'd1);
        if (got_frames.size() > base_f) check("gap_data", 64'(got_frames[base_f]), 64'(ef));

        // Reset mid-frame
        send_word(mkw(8'hC3, 0), 0);
        send_word(mkw(8'h3C, 0), 0);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_pop_grant", 64'(pop_grant_o), 64'd0);
        check("mid_rst_valid", 64'(frame_valid_o), 64'd0);
        check("mid_rst_data", 64'(frame_data_o), 64'd0);
        check("mid_rst_error", 64'(frame_error_o), 64'd0);
        check("mid_rst_count", 64'(err_count_o), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        send_word({1'b0, 8'hAA}, 0);
        send_word({1'b0, 8'h55}, 0);
        send_word({1'b1, 8'h01}, 0);
        send_word({1'b0, 8'h00}, 0);
        check("mid_rst_frame_valid", 64'(frame_valid_o), 64'd1);
        check("mid_rst_frame_data", 64'(frame_data_o), 64'h000155AA);
        @(negedge clk);

        // Saturating error counter
        for (int i = 1; i <= 256; i++) begin
            send_word(mkw(8'($urandom), 1), 0);
            for (int k = 1; k < NW; k++) send_word(mkw(8'($urandom), 0), 0);
            check("sat_count", 64'(err_count_o), (i < 255) ? 64'(i) : 64'd255);
            if (i >= 255) check("sat_pulse", 64'(frame_error_o), 64'd1);
        end
        @(negedge clk);

        // Randomized traffic against frame-level model
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        base_f = got_frames.size();
        base_e = err_pulses;
        exp_bad = 0;
        rand_grant = 1'b1;
        for (int f = 0; f < 40; f++) begin
            fbad = 1'b0;
            ef = '0;
            for (int k = 0; k < NW; k++) begin
                pl = 8'($urandom);
                rb = ($urandom_range(0, 6) == 0);
                fbad |= rb;
                ef |= (NW*DW)'(pl) << (DW * k);
                send_word(mkw(pl, rb), $urandom_range(0, 2));
            end
            if (fbad) exp_bad++;
            else exp_frames.push_back(ef);
        end
        rand_grant = 1'b0;
        frame_grant_i = 1'b1;
        repeat (5) @(negedge clk);
        check("rnd_nframes", 64'(got_frames.size() - base_f), 64'(exp_frames.size()));
        for (int i = 0; i < exp_frames.size(); i++) begin
            if (base_f + i < got_frames.size())
                check("rnd_frame", 64'(got_frames[base_f + i]), 64'(exp_frames[i]));
        end
        check("rnd_err_pulses", 64'(err_pulses - base_e), 64'(exp_bad));
        check("rnd_err_count", 64'(err_count_o), 64'(exp_bad));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
